// File: rtl/uart_pkg.sv
// Types shared by the UART receiver and transmitter: parity selection and
// receiver FSM states, plus the width of the per-frame bit index.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  // Wide enough to index up to 9 data bits or 2 stop bits.
  localparam int IDX_W = 4;

endpackage

// File: rtl/uart_rx_param_if.sv
// Receiver-side bundle: raw serial line in, received word and status flags out.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);

  logic                 bit_in;
  logic [DATA_BITS-1:0] byte_out;
  logic                 ready_out;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  bit_in,
    output byte_out, ready_out, parity_err, frame_err, busy
  );

  modport slave (
    output bit_in,
    input  byte_out, ready_out, parity_err, frame_err, busy
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, in-bit cycle counter and 3-sample majority vote.
// bit_valid marks the cycle in which bit_val holds the voted value of the current bit.
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  input  logic run,
  output logic rx_s,
  output logic bit_valid,
  output logic bit_val,
  output logic cnt_wrap
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] C_EARLY = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] C_MID   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] C_DEC   = CNT_W'(HALF + 1);
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync_p0, sync_p1;
  logic             samp_a, samp_b;
  logic [CNT_W-1:0] cnt;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Stage p0/p1: synchroniser flops preset to idle-high so reset release never looks like a start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      samp_a  <= 1'b1;
      samp_b  <= 1'b1;
      cnt     <= '0;
    end else begin
      sync_p0 <= bit_in;
      sync_p1 <= sync_p0;
      if (!run || cnt_wrap) cnt <= '0;
      else                  cnt <= cnt + CNT_W'(1);
      if (cnt == C_EARLY) samp_a <= sync_p1;
      if (cnt == C_MID)   samp_b <= sync_p1;
    end
  end

  assign rx_s      = sync_p1;
  assign bit_valid = (cnt == C_DEC);
  assign bit_val   = maj3(samp_a, samp_b, sync_p1);
  assign cnt_wrap  = (cnt == C_LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, LSB-first shift register, parity and
// stop-bit checking. Word and flags update only in the cycle ready_out pulses.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = 16,
  parameter int      DATA_BITS    = 8,
  parameter parity_e PARITY_MODE  = PAR_NONE,
  parameter int      STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_param_if.master rx
);

  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  rx_state_e            state;
  logic [DATA_BITS-1:0] shreg;
  logic [IDX_W-1:0]     bit_idx;
  logic                 par_err_acc;
  logic                 ferr_acc;
  logic                 run;
  logic                 rx_s, bit_valid, bit_val, cnt_wrap;

  function automatic logic expected_parity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_MODE == PAR_ODD);
  endfunction

  uart_rx_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_sampler (
    .clk      (clk),
    .reset    (reset),
    .bit_in   (rx.bit_in),
    .run      (run),
    .rx_s     (rx_s),
    .bit_valid(bit_valid),
    .bit_val  (bit_val),
    .cnt_wrap (cnt_wrap)
  );

  // The bit counter runs only while a frame is live, and restarts from 0 on every return to IDLE.
  always_comb begin
    run = 1'b1;
    case (state)
      IDLE:      run = !rx_s;
      START:     run = !(bit_valid && bit_val);
      STOP:      run = !(bit_valid && (bit_idx == LAST_STOP));
      WAIT_IDLE: run = 1'b0;
      default:   run = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      shreg         <= '0;
      bit_idx       <= '0;
      par_err_acc   <= 1'b0;
      ferr_acc      <= 1'b0;
      rx.byte_out   <= '0;
      rx.ready_out  <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;
    end else begin
      rx.ready_out <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state       <= START;
          bit_idx     <= '0;
          par_err_acc <= 1'b0;
          ferr_acc    <= 1'b0;
        end
        START: begin
          if (bit_valid && bit_val) state <= IDLE;
          else if (cnt_wrap)        state <= DATA;
        end
        DATA: if (bit_valid) begin
          shreg <= {bit_val, shreg[DATA_BITS-1:1]};
          if (bit_idx == LAST_DATA) begin
            bit_idx <= '0;
            state   <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
          end else begin
            bit_idx <= bit_idx + IDX_W'(1);
          end
        end
        PARITY: if (bit_valid) begin
          par_err_acc <= (bit_val != expected_parity(shreg));
          state       <= STOP;
        end
        // Re-arm at the last stop-bit decision rather than its end to absorb baud mismatch.
        STOP: if (bit_valid) begin
          if (bit_idx == LAST_STOP) begin
            rx.byte_out   <= shreg;
            rx.parity_err <= par_err_acc;
            rx.frame_err  <= ferr_acc | ~bit_val;
            rx.ready_out  <= 1'b1;
            state         <= bit_val ? IDLE : WAIT_IDLE;
          end else begin
            ferr_acc <= ferr_acc | ~bit_val;
            bit_idx  <= bit_idx + IDX_W'(1);
          end
        end
        WAIT_IDLE: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rx.busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receivers (8N1, 8E1, 9O2) each on its own line,
// frames checked against a frame-level reference model and the spec's fixed cases.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int CPB = 16;

  typedef struct packed {
    logic [31:0] cyc;
    logic [8:0]  data;
    logic        pe;
    logic        fe;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] line = 3'b111;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         hold_viol = 0;
  rec_t       got_a[$], got_b[$], got_c[$];

  uart_rx_param_if #(.DATA_BITS(8)) ifa ();
  uart_rx_param_if #(.DATA_BITS(8)) ifb ();
  uart_rx_param_if #(.DATA_BITS(9)) ifc ();

  assign ifa.bit_in = line[0];
  assign ifb.bit_in = line[1];
  assign ifc.bit_in = line[2];

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(PAR_NONE), .STOP_BITS(1))
    dut_a (.clk(clk), .reset(reset), .rx(ifa));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(PAR_EVEN), .STOP_BITS(1))
    dut_b (.clk(clk), .reset(reset), .rx(ifb));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY_MODE(PAR_ODD), .STOP_BITS(2))
    dut_c (.clk(clk), .reset(reset), .rx(ifc));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Collect every delivered word with the cycle it appeared in.
  always @(negedge clk) begin
    if (ifa.ready_out) got_a.push_back('{32'(cyc), {1'b0, ifa.byte_out}, ifa.parity_err, ifa.frame_err});
    if (ifb.ready_out) got_b.push_back('{32'(cyc), {1'b0, ifb.byte_out}, ifb.parity_err, ifb.frame_err});
    if (ifc.ready_out) got_c.push_back('{32'(cyc), ifc.byte_out, ifc.parity_err, ifc.frame_err});
  end

  // Outputs may only move on a ready_out cycle, and ready_out is a single-cycle pulse.
  logic [7:0] prev_a_d;
  logic [8:0] prev_c_d;
  logic [1:0] prev_a_f, prev_c_f;
  logic       prev_a_r, prev_c_r;
  always @(negedge clk) begin
    if (!reset) begin
      if (!ifa.ready_out && (ifa.byte_out !== prev_a_d || {ifa.parity_err, ifa.frame_err} !== prev_a_f))
        hold_viol++;
      if (!ifc.ready_out && (ifc.byte_out !== prev_c_d || {ifc.parity_err, ifc.frame_err} !== prev_c_f))
        hold_viol++;
      if ((ifa.ready_out && prev_a_r) || (ifc.ready_out && prev_c_r)) hold_viol++;
    end
    prev_a_d = ifa.byte_out; prev_a_f = {ifa.parity_err, ifa.frame_err}; prev_a_r = ifa.ready_out;
    prev_c_d = ifc.byte_out; prev_c_f = {ifc.parity_err, ifc.frame_err}; prev_c_r = ifc.ready_out;
  end

  // Frame-level model: what the receiver should report and when (2 cycles of line synchronisation
  // between the line edge and the start edge, ready half a bit plus 2 cycles into the last stop bit).
  function automatic rec_t model(input int c0, input logic [8:0] d, input int nbits, input int pmode,
                                 input logic pbit, input int nstop, input logic [1:0] stops);
    rec_t       r;
    logic [8:0] m;
    int         ones;
    int         nframe;
    m      = d & 9'((1 << nbits) - 1);
    ones   = $countones(m);
    nframe = 1 + nbits + ((pmode != 0) ? 1 : 0) + nstop;
    r.cyc  = 32'(c0 + 2 + (nframe - 1) * CPB + CPB / 2 + 2);
    r.data = m;
    if (pmode == 0)      r.pe = 1'b0;
    else if (pmode == 1) r.pe = (pbit != ((ones % 2) == 1));
    else                 r.pe = (pbit != ((ones % 2) == 0));
    r.fe = !stops[0] || (nstop == 2 && !stops[1]);
    return r;
  endfunction

  // Drives one frame on line[ch]; per100 is the bit period in hundredths of a clock. Called and
  // returns on a falling clock edge; c0 is the cycle count at the moment the start bit begins.
  task automatic send_frame(input int ch, input logic [8:0] d, input int nbits, input bit has_par,
                            input logic pbit, input int nstop, input logic [1:0] stops,
                            input int per100, output int c0);
    logic bits[$];
    int   prev_end, end_c;
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bits.push_back(d[i]);
    if (has_par) bits.push_back(pbit);
    for (int i = 0; i < nstop; i++) bits.push_back(stops[i]);
    c0 = cyc;
    prev_end = 0;
    foreach (bits[i]) begin
      line[ch] = bits[i];
      end_c = ((i + 1) * per100 + 50) / 100;
      repeat (end_c - prev_end) @(negedge clk);
      prev_end = end_c;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    line  = 3'b111;
    repeat (3) @(negedge clk);
    checks++; if (ifa.byte_out !== 8'h00) begin failures++; $display("FAIL reset_byte_out got=%h want=00", ifa.byte_out); end
    checks++; if (ifa.ready_out !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", ifa.ready_out); end
    checks++; if (ifa.parity_err !== 1'b0 || ifa.frame_err !== 1'b0)
      begin failures++; $display("FAIL reset_flags got=%b%b want=00", ifa.parity_err, ifa.frame_err); end
    checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", ifa.busy); end
    checks++; if (ifc.byte_out !== 9'h000) begin failures++; $display("FAIL reset_byte_out9 got=%h want=000", ifc.byte_out); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (ifa.busy !== 1'b0 || got_a.size() != 0)
      begin failures++; $display("FAIL reset_release busy=%b words=%0d want busy=0 words=0", ifa.busy, got_a.size()); end
  endtask

  task automatic test_basic();
    int   c0, gap;
    rec_t e, g;
    logic [8:0] d;
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 2'b11, CPB * 100, c0);
    repeat (2) @(negedge clk);
    checks++;
    if (got_a.size() != 1) begin failures++; $display("FAIL a5_count got=%0d want=1", got_a.size()); end
    else begin
      g = got_a.pop_front();
      checks++; if (int'(g.cyc) - c0 - 2 != 154) begin failures++; $display("FAIL a5_latency got=%0d want=154", int'(g.cyc) - c0 - 2); end
      checks++; if (g.data !== 9'h0A5) begin failures++; $display("FAIL a5_data got=%h want=a5", g.data); end
      checks++; if (g.pe !== 1'b0 || g.fe !== 1'b0) begin failures++; $display("FAIL a5_flags got=%b%b want=00", g.pe, g.fe); end
    end
    for (int i = 0; i < 4; i++) begin
      d   = 9'($urandom_range(0, 255));
      gap = $urandom_range(0, 4);
      send_frame(0, d, 8, 1'b0, 1'b0, 1, 2'b11, CPB * 100, c0);
      e = model(c0, d, 8, 0, 1'b0, 1, 2'b11);
      checks++;
      if (got_a.size() != 1) begin failures++; $display("FAIL rand8_count%0d got=%0d want=1", i, got_a.size()); got_a.delete(); end
      else begin
        g = got_a.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL rand8_frame%0d got cyc=%0d d=%h pe=%b fe=%b want cyc=%0d d=%h pe=%b fe=%b",
                   i, g.cyc, g.data, g.pe, g.fe, e.cyc, e.data, e.pe, e.fe);
        end
      end
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic test_parity();
    int   c0;
    rec_t g;
    for (int k = 0; k < 2; k++) begin
      send_frame(1, 9'h007, 8, 1'b1, logic'(k), 1, 2'b11, CPB * 100, c0);
      repeat (2) @(negedge clk);
      checks++;
      if (got_b.size() != 1) begin failures++; $display("FAIL par07_count%0d got=%0d want=1", k, got_b.size()); got_b.delete(); end
      else begin
        g = got_b.pop_front();
        if (g.data !== 9'h007 || g.pe !== logic'(k == 0) || g.fe !== 1'b0 || int'(g.cyc) - c0 != 172) begin
          failures++;
          $display("FAIL par07_pbit%0d got d=%h pe=%b fe=%b lat=%0d want d=007 pe=%b fe=0 lat=172",
                   k, g.data, g.pe, g.fe, int'(g.cyc) - c0, (k == 0));
        end
      end
    end
  endtask

  task automatic test_nine_bit_random();
    int         c0, gap;
    rec_t       e, g;
    logic [8:0] d;
    logic       pbit;
    logic [1:0] stops;
    send_frame(2, 9'h100, 9, 1'b1, 1'b0, 2, 2'b11, CPB * 100, c0);
    line[2] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (got_c.size() != 1) begin failures++; $display("FAIL bit8_count got=%0d want=1", got_c.size()); got_c.delete(); end
    else begin
      g = got_c.pop_front();
      if (g.data[8] !== 1'b1 || g.data !== 9'h100 || g.pe !== 1'b0 || g.fe !== 1'b0)
        begin failures++; $display("FAIL bit8_word got d=%h pe=%b fe=%b want d=100 pe=0 fe=0", g.data, g.pe, g.fe); end
    end
    for (int i = 0; i < 6; i++) begin
      d     = 9'($urandom_range(0, 511));
      pbit  = 1'($urandom_range(0, 1));
      stops = 2'($urandom_range(0, 3));
      gap   = $urandom_range(1, 20);
      send_frame(2, d, 9, 1'b1, pbit, 2, stops, CPB * 100, c0);
      e = model(c0, d, 9, 2, pbit, 2, stops);
      line[2] = 1'b1;
      checks++;
      if (got_c.size() != 1) begin failures++; $display("FAIL rand9_count%0d got=%0d want=1", i, got_c.size()); got_c.delete(); end
      else begin
        g = got_c.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL rand9_frame%0d got cyc=%0d d=%h pe=%b fe=%b want cyc=%0d d=%h pe=%b fe=%b",
                   i, g.cyc, g.data, g.pe, g.fe, e.cyc, e.data, e.pe, e.fe);
        end
      end
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic test_glitch();
    int  k;
    line[0] = 1'b0;
    repeat (3) @(negedge clk);
    line[0] = 1'b1;
    checks++; if (ifa.busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_seen got=%b want=1", ifa.busy); end
    k = 0;
    while (ifa.busy !== 1'b0 && k < 12) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k > 9) begin failures++; $display("FAIL glitch_busy_clear got=%0d cycles want<=9", k); end
    repeat (40) @(negedge clk);
    checks++; if (got_a.size() != 0) begin failures++; $display("FAIL glitch_no_ready got=%0d want=0", got_a.size()); got_a.delete(); end
  endtask

  task automatic test_frame_err();
    int   c0;
    rec_t g, e;
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 2'b00, CPB * 100, c0);
    repeat (40 * CPB) @(negedge clk);
    checks++;
    if (got_a.size() != 1) begin failures++; $display("FAIL ferr_count got=%0d want=1", got_a.size()); got_a.delete(); end
    else begin
      g = got_a.pop_front();
      if (g.data !== 9'h03C || g.fe !== 1'b1 || g.pe !== 1'b0)
        begin failures++; $display("FAIL ferr_word got d=%h pe=%b fe=%b want d=03c pe=0 fe=1", g.data, g.pe, g.fe); end
    end
    checks++; if (ifa.busy !== 1'b1) begin failures++; $display("FAIL ferr_wait_busy got=%b want=1", ifa.busy); end
    line[0] = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL ferr_recover_busy got=%b want=0", ifa.busy); end
    send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1, 2'b11, CPB * 100, c0);
    e = model(c0, 9'h081, 8, 0, 1'b0, 1, 2'b11);
    checks++;
    if (got_a.size() != 1) begin failures++; $display("FAIL ferr_next_count got=%0d want=1", got_a.size()); got_a.delete(); end
    else begin
      g = got_a.pop_front();
      if (g !== e || g.fe !== 1'b0)
        begin failures++; $display("FAIL ferr_next_word got cyc=%0d d=%h fe=%b want cyc=%0d d=081 fe=0", g.cyc, g.data, g.fe, e.cyc); end
    end
  endtask

  task automatic test_back_to_back();
    int   c1, c2;
    rec_t e1, e2, g;
    send_frame(0, 9'h000, 8, 1'b0, 1'b0, 1, 2'b11, 1632, c1);
    send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 2'b11, 1632, c2);
    e1 = model(c1, 9'h000, 8, 0, 1'b0, 1, 2'b11);
    e2 = model(c2, 9'h0FF, 8, 0, 1'b0, 1, 2'b11);
    repeat (4) @(negedge clk);
    checks++;
    if (got_a.size() != 2) begin failures++; $display("FAIL b2b_count got=%0d want=2", got_a.size()); got_a.delete(); end
    else begin
      g = got_a.pop_front();
      checks++; if (g !== e1) begin failures++; $display("FAIL b2b_first got cyc=%0d d=%h fe=%b want cyc=%0d d=000 fe=0", g.cyc, g.data, g.fe, e1.cyc); end
      g = got_a.pop_front();
      checks++; if (g !== e2) begin failures++; $display("FAIL b2b_second got cyc=%0d d=%h fe=%b want cyc=%0d d=0ff fe=0", g.cyc, g.data, g.fe, e2.cyc); end
    end
  endtask

  task automatic test_reset_mid();
    int         c0;
    rec_t       e, g;
    logic [4:0] head;
    head = 5'b01010;  // start bit then data bits 0..3 of 0x55, sent head[0] first
    for (int i = 0; i < 5; i++) begin
      line[0] = head[i];
      repeat (CPB) @(negedge clk);
    end
    line[0] = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (ifa.byte_out !== 8'h00 || ifa.parity_err !== 1'b0 || ifa.frame_err !== 1'b0)
      begin failures++; $display("FAIL rstmid_outputs got d=%h pe=%b fe=%b want d=00 pe=0 fe=0", ifa.byte_out, ifa.parity_err, ifa.frame_err); end
    checks++; if (ifa.busy !== 1'b0 || ifa.ready_out !== 1'b0)
      begin failures++; $display("FAIL rstmid_ctrl got busy=%b ready=%b want 0 0", ifa.busy, ifa.ready_out); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    checks++; if (got_a.size() != 0) begin failures++; $display("FAIL rstmid_no_ready got=%0d want=0", got_a.size()); got_a.delete(); end
    send_frame(0, 9'h012, 8, 1'b0, 1'b0, 1, 2'b11, CPB * 100, c0);
    e = model(c0, 9'h012, 8, 0, 1'b0, 1, 2'b11);
    checks++;
    if (got_a.size() != 1) begin failures++; $display("FAIL rstmid_next_count got=%0d want=1", got_a.size()); got_a.delete(); end
    else begin
      g = got_a.pop_front();
      if (g !== e) begin failures++; $display("FAIL rstmid_next_word got cyc=%0d d=%h want cyc=%0d d=012", g.cyc, g.data, e.cyc); end
    end
  endtask

  task automatic test_hold();
    repeat (4) @(negedge clk);
    checks++; if (hold_viol != 0) begin failures++; $display("FAIL output_hold got=%0d violations want=0", hold_viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_nine_bit_random();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
